// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, controller state encoding and flag bit positions shared by the ALU core and its datapath.
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                         OP_MUL = 3'd4, OP_DIV = 3'd5, OP_XOR = 3'd6, OP_ILL = 3'd7;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
  localparam int FLAG_ZERO = 0, FLAG_CARRY = 1, FLAG_ERR = 2, NFLAGS = 3;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: W-iteration shift-add multiplier / restoring divider. Ports: clk, rst_n (sync, active-low),
// start/mode (0 mul, 1 div) load a,b; busy while iterating; last marks the final iteration, whose result is on nxt.
module muldiv_iter #(parameter int W = 8) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           last,
  output logic [2*W-1:0] nxt
);
  localparam int CW = $clog2(W + 1);
  logic [CW-1:0]  cnt;
  logic           md;
  logic [2*W-1:0] acc, opb, acc_n, opb_n;
  logic [W-1:0]   sh, sh_n;
  logic [W:0]     t, r;
  logic           ge;
  assign busy = cnt != '0;
  assign last = cnt == CW'(1);
  // Divide: acc holds the partial remainder, sh shifts the dividend out and the quotient in.
  // Multiply: acc accumulates, opb is the left-shifting multiplicand, sh the right-shifting multiplier.
  always_comb begin
    t     = {acc[W-1:0], sh[W-1]};
    ge    = t >= opb[W:0];
    r     = ge ? t - opb[W:0] : t;
    acc_n = md ? {{(W-1){1'b0}}, r} : acc + (sh[0] ? opb : '0);
    opb_n = md ? opb : opb << 1;
    sh_n  = md ? {sh[W-2:0], ge} : sh >> 1;
    nxt   = md ? {acc_n[W-1:0], sh_n} : acc_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      md  <= 1'b0;
      acc <= '0;
      opb <= '0;
      sh  <= '0;
    end else if (start) begin
      cnt <= CW'(W);
      md  <= mode;
      acc <= '0;
      opb <= {{W{1'b0}}, b};
      sh  <= a;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      acc <= acc_n;
      opb <= opb_n;
      sh  <= sh_n;
    end
  end
endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: registered W-bit ALU with valid/ready handshakes. Ports: clk, rst_n (sync, active-low);
// in_valid/in_ready, op, a, b command side; out_valid/out_ready, result (2W), flag_zero/carry/err result side.
module alu_seq_core
  import alu_pkg::*;
#(parameter int W = 8) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           flag_zero,
  output logic           flag_carry,
  output logic           flag_err
);
  state_t              state, state_n;
  logic [NFLAGS-1:0]   flags, sflags, mflags;
  logic                accept, is_multi, md_busy, md_last;
  logic [2*W-1:0]      single_res, md_nxt;
  logic [W:0]          sum, diff;
  assign in_ready   = rst_n && state == S_IDLE;
  assign accept     = in_valid && in_ready;
  assign is_multi   = op == OP_MUL || (op == OP_DIV && b != '0);
  assign flag_zero  = flags[FLAG_ZERO];
  assign flag_carry = flags[FLAG_CARRY];
  assign flag_err   = flags[FLAG_ERR];
  muldiv_iter #(.W(W)) u_md (
    .clk(clk), .rst_n(rst_n), .start(accept && is_multi), .mode(op == OP_DIV),
    .a(a), .b(b), .busy(md_busy), .last(md_last), .nxt(md_nxt)
  );
  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    diff       = {1'b0, a} - {1'b0, b};
    single_res = op == OP_AND ? {{W{1'b0}}, a & b} :
                 op == OP_OR  ? {{W{1'b0}}, a | b} :
                 op == OP_XOR ? {{W{1'b0}}, a ^ b} :
                 op == OP_ADD ? {{W{1'b0}}, sum[W-1:0]} :
                 op == OP_SUB ? {{W{1'b0}}, diff[W-1:0]} :
                 op == OP_DIV ? {a, {W{1'b1}}} : '0;
    sflags             = '0;
    sflags[FLAG_ZERO]  = single_res == '0;
    sflags[FLAG_CARRY] = op == OP_ADD ? sum[W] : op == OP_SUB && diff[W];
    sflags[FLAG_ERR]   = op == OP_ILL || op == OP_DIV;
    mflags             = '0;
    mflags[FLAG_ZERO]  = md_nxt == '0;
    // A multi-cycle state with an idle datapath cannot complete; fall back to IDLE rather than hang.
    state_n = state == S_IDLE ? (accept ? (op == OP_MUL ? S_MUL : is_multi ? S_DIV : S_DONE) : S_IDLE) :
              state == S_DONE ? (out_ready ? S_IDLE : S_DONE) :
              md_last ? S_DONE : md_busy ? state : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else if (accept && !is_multi) begin
      result    <= single_res;
      flags     <= sflags;
      out_valid <= 1'b1;
    end else if ((state == S_MUL || state == S_DIV) && md_last) begin
      result    <= md_nxt;
      flags     <= mflags;
      out_valid <= 1'b1;
    end else if (state == S_DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed vectors checked against an arithmetic model plus hand-computed literal results.
module tb_alu_seq_core;
  localparam int W = 8;
  logic           clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0]     op = '0;
  logic [W-1:0]   a = '0, b = '0;
  logic           in_ready, out_valid, flag_zero, flag_carry, flag_err;
  logic [2*W-1:0] result;
  int             checks = 0, errors = 0;
  bit             track = 1'b0;
  logic [15:0]    exp_r;
  logic [2:0]     exp_f;
  always #5 clk = ~clk;
  alu_seq_core #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_err(flag_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask
  // f = {err, carry, zero}; lat = negedge samples after the accept edge until out_valid is seen.
  function automatic void model(input logic [2:0] o, input int x, input int y,
                                output logic [15:0] r, output logic [2:0] f, output int lat);
    int s;
    r = '0; f = '0; lat = 1;
    case (o)
      3'd0: r = 16'(x & y);
      3'd1: r = 16'(x | y);
      3'd6: r = 16'(x ^ y);
      3'd2: begin s = x + y; r = 16'(s % 256); f[1] = s > 255; end
      3'd3: begin r = 16'((x - y + 256) % 256); f[1] = x < y; end
      3'd4: begin r = 16'(x * y); lat = 9; end
      3'd5: if (y == 0) begin r = 16'(x * 256 + 255); f[2] = 1'b1; end
            else begin r = 16'((x % y) * 256 + x / y); lat = 9; end
      default: f[2] = 1'b1;
    endcase
    f[0] = r == 16'd0;
  endfunction
  always @(negedge clk) begin
    if (track) begin
      chk("in_ready_busy", in_ready, 0);
      if (out_valid) begin
        chk("result", result, exp_r);
        chk("flags", {flag_err, flag_carry, flag_zero}, exp_f);
      end
    end
  end
  task automatic run(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] lit, input int hold, input bit noise);
    int k, lat;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    chk("idle_ready", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    model(o, int'(x), int'(y), exp_r, exp_f, lat);
    @(posedge clk); #1;
    in_valid = noise; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    track = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 40);
    chk("latency", k, lat);
    chk("lit_result", result, lit);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0; track = 1'b0;
    @(negedge clk);
    chk("ready_after", in_ready, 1);
    chk("valid_after", out_valid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_err, flag_carry, flag_zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    run(3'd2, 8'hFF, 8'h01, 16'h0000, 0, 0);
    run(3'd3, 8'h03, 8'h05, 16'h00FE, 0, 0);
    run(3'd4, 8'd200, 8'd200, 16'h9C40, 0, 1);
    run(3'd5, 8'd200, 8'd7, 16'h041C, 1, 0);
    run(3'd5, 8'h55, 8'h00, 16'h55FF, 0, 1);
    run(3'd6, 8'hF0, 8'h3C, 16'h00CC, 5, 1);
    run(3'd0, 8'hCC, 8'hAA, 16'h0088, 0, 0);
    run(3'd1, 8'h0F, 8'h30, 16'h003F, 2, 0);
    run(3'd7, 8'h12, 8'h34, 16'h0000, 0, 0);
    run(3'd4, 8'h00, 8'h4D, 16'h0000, 0, 0);
    run(3'd4, 8'hFF, 8'hFF, 16'hFE01, 3, 1);
    run(3'd5, 8'hFF, 8'hFF, 16'h0001, 0, 0);
    run(3'd5, 8'h05, 8'h09, 16'h0500, 0, 0);
    run(3'd3, 8'h05, 8'h05, 16'h0000, 0, 0);
    run(3'd2, 8'h80, 8'h7F, 16'h00FF, 0, 0);
    @(negedge clk);
    op = 3'd4; a = 8'd200; b = 8'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", {flag_err, flag_carry, flag_zero}, 0);
    chk("abort_in_ready", in_ready, 0);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    run(3'd2, 8'd2, 8'd3, 16'h0005, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised successor to the team's 4-bit tiny-tapeout ALU: a registered W-bit ALU with valid/ready handshakes on input and output. It adds iterative multiply and divide, a full-width result, and status flags. It sits between the pin-level input latch and the output mux of the top-level user module. It replaces the single-cycle combinational case statement with a small controller plus an iterative datapath.

## Interface
Parameters:
- W, default 8. Operand width; legal range 2 to 16.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands and opcode are presented.
- in_ready  out  1  the core can accept a command; high only in IDLE while rst_n=1.
- op  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 MUL, 101 DIV, 110 XOR, 111 illegal.
- a, b  in  W  unsigned operands.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  the consumer accepts the result.
- result  out  2W  registered result.
- flag_zero  out  1  result == 0.
- flag_carry  out  1  carry out (ADD) or borrow (SUB); 0 for all other ops.
- flag_err  out  1  divide by zero or illegal opcode.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept: a command is accepted when in_valid && in_ready. a, b and op are captured on that edge. The inputs are don't-care afterwards.
- Single-cycle ops (AND, OR, XOR, ADD, SUB, illegal, DIV with b==0): IDLE -> DONE on the accept edge.
  - result[W-1:0] holds the op result; result[2W-1:W] = 0.
- ADD: result[W-1:0] = (a+b) mod 2^W; flag_carry = bit W of the (W+1)-bit sum.
- SUB: result[W-1:0] = (a-b) mod 2^W; flag_carry = 1 if a<b.
- Illegal (111): result = 0, flag_err = 1.
- MUL: IDLE -> MUL. Shift-add, one multiplier bit per cycle, W iterations, then -> DONE. result = full 2W-bit product.
- DIV with b != 0: IDLE -> DIV. Restoring division, one quotient bit per cycle, W iterations, then -> DONE.
  - result[W-1:0] = quotient; result[2W-1:W] = remainder.
- DIV with b == 0: result[W-1:0] = all ones, result[2W-1:W] = a, flag_err = 1.
- flag_zero is computed on the final 2W-bit result and is valid for every op.
- DONE: out_valid = 1. result and flags are held stable until out_ready = 1; on that edge -> IDLE.
- No command overlap: in_ready = 0 in MUL, DIV and DONE.
- Reset, synchronous with rst_n = 0:
  - state -> IDLE.
  - out_valid, result, all flags and the iteration counter -> 0.
  - in_ready = 0 while rst_n = 0.
  - Reset during MUL/DIV/DONE aborts the operation; no out_valid is produced for it.

## Timing
- Single-cycle ops: out_valid rises 1 cycle after the accept edge.
- MUL and DIV (b != 0): out_valid rises W+1 cycles after the accept edge (9 for W=8).
- Iteration counter width: clog2(W+1). It counts W down to 0; the transition to DONE happens when the count reaches 1.
- Maximum throughput:
  - single-cycle op: 1 per 2 cycles with out_ready tied high;
  - MUL/DIV: 1 per W+2 cycles.
- out_ready asserted together with out_valid: return to IDLE on that edge; in_ready is high the next cycle.
- in_valid held high in a non-IDLE state is ignored, not queued.
- The outputs are glitch-free registered values; no output is a combinational function of the inputs except in_ready, which decodes state and rst_n.

## Structure
- Package alu_pkg:
  - opcode localparams (OP_AND ... OP_ILL);
  - state encoding (IDLE=0, MUL=1, DIV=2, DONE=3);
  - flag bit positions.
- Sub-module muldiv_iter:
  - holds the W-iteration shift-add / restoring-divide datapath: accumulator, partial remainder, operand shift registers;
  - start/mode inputs, busy/done outputs.
- alu_seq_core owns the FSM, the single-cycle ops, the handshakes and the flags.
- The tiny-tapeout top wraps the core with W=4: ui_in split into a/b, uio_in[2:0] = op, uo_out = result[7:0].

## Test plan
(All with W=8.)
- ADD a=0xFF, b=0x01 -> result 0x0000, flag_carry=1, flag_zero=1, out_valid 1 cycle after accept.
- SUB a=0x03, b=0x05 -> result 0x00FE, flag_carry=1, flag_zero=0.
- MUL a=200, b=200 -> result 0x9C40, out_valid exactly 9 cycles after accept, in_ready low throughout.
- DIV a=200, b=7 -> result 0x041C (remainder 4, quotient 28) after 9 cycles; DIV a=0x55, b=0 -> result 0x55FF, flag_err=1, after 1 cycle.
- Backpressure: out_ready low for 5 cycles after an XOR a=0xF0, b=0x3C:
  - result holds 0x00CC and in_ready stays 0 throughout;
  - on the out_ready edge, in_ready rises the next cycle.
- Reset at cycle 4 of a MUL:
  - next cycle: out_valid=0, result=0, all flags 0;
  - after rst_n returns high, in_ready=1 and a new ADD 2+3 returns 0x0005.
